// File: rtl/interrupt_ack_sequencer.sv
// Purpose : CPU-facing end of the interrupt path; raises INT, runs the two-pulse INTA acknowledge, keeps the ISR and services EOI.
// Latency : int_out 1 clk after a request in IDLE; ISR/clear_irr/data_out 1 clk after the sampled INTA edge.
// Backpressure: none; the CPU paces the sequence through inta_n, and requests are held off while an acknowledge is in progress.
//
// Ports:
//   clk, rst_n               - clock (rising edge) and asynchronous active-low reset
//   interrupt[7:0]           - one-hot winning request from the priority resolver (lowest index wins if several)
//   inta_n                   - CPU acknowledge, active low, already synchronous to clk
//   eoi_valid/specific/level - one-cycle EOI command; specific clears eoi_level, non-specific clears lowest ISR bit
//   vector_base[4:0]         - upper five bits of the vector byte
//   int_out                  - interrupt request to the CPU
//   in_service_register      - ISR
//   highest_level_in_service - one-hot lowest-index set ISR bit, 0 when ISR empty
//   clear_irr                - one-cycle one-hot pulse dropping the acknowledged IRR bit
//   data_out/data_oe         - vector byte and its bus drive enable (data_out is 0 when not driving)
module interrupt_ack_sequencer #(
    parameter bit         AUTO_EOI       = 1'b0,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [7:0] clear_irr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK1,
        ST_WAIT2,
        ST_ACK2
    } state_t;

    state_t     state_q, state_d;
    logic       int_out_q, int_out_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic       inta_prev_q;

    logic       inta_fall, inta_rise;
    logic [7:0] req_oh;
    logic [2:0] req_lvl;
    logic [7:0] isr_low;
    logic [7:0] eoi_clr;
    logic [7:0] auto_clr;
    logic [7:0] isr_set;

    always_comb begin
        inta_fall = inta_prev_q & ~inta_n;
        inta_rise = ~inta_prev_q & inta_n;

        // x & -x isolates the lowest set bit.
        req_oh  = interrupt & (~interrupt + 8'd1);
        isr_low = isr_q & (~isr_q + 8'd1);

        req_lvl = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (interrupt[i]) begin
                req_lvl = 3'(i);
            end
        end

        eoi_clr = 8'd0;
        if (eoi_valid) begin
            eoi_clr = eoi_specific ? (8'd1 << eoi_level) : isr_low;
        end

        state_d     = state_q;
        int_out_d   = int_out_q;
        clear_irr_d = 8'd0;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        level_d     = level_q;
        spurious_d  = spurious_q;
        isr_set     = 8'd0;
        auto_clr    = 8'd0;

        case (state_q)
            ST_IDLE: begin
                // Stray INTA edges here are ignored; only a request moves us on.
                if (interrupt != 8'd0) begin
                    int_out_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // int_out is held even if the request vanishes; a vanished
                // request turns into a spurious acknowledge at the first INTA.
                if (inta_fall) begin
                    int_out_d = 1'b0;
                    state_d   = ST_ACK1;
                    if (interrupt != 8'd0) begin
                        level_d     = req_lvl;
                        spurious_d  = 1'b0;
                        isr_set     = req_oh;
                        clear_irr_d = req_oh;
                    end else begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_d = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (inta_fall) begin
                    data_out_d = {vector_base, level_q};
                    data_oe_d  = 1'b1;
                    state_d    = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    data_out_d = 8'd0;
                    data_oe_d  = 1'b0;
                    state_d    = ST_IDLE;
                    if (AUTO_EOI && !spurious_q) begin
                        auto_clr = 8'd1 << level_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Set applied last so an INTA set beats an EOI clear on the same bit.
        isr_d = (isr_q & ~eoi_clr & ~auto_clr) | isr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            int_out_q   <= 1'b0;
            isr_q       <= 8'd0;
            clear_irr_q <= 8'd0;
            data_out_q  <= 8'd0;
            data_oe_q   <= 1'b0;
            level_q     <= 3'd0;
            spurious_q  <= 1'b0;
            inta_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            int_out_q   <= int_out_d;
            isr_q       <= isr_d;
            clear_irr_q <= clear_irr_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            level_q     <= level_d;
            spurious_q  <= spurious_d;
            inta_prev_q <= inta_n;
        end
    end

    assign int_out                  = int_out_q;
    assign in_service_register      = isr_q;
    assign highest_level_in_service = isr_low;
    assign clear_irr                = clear_irr_q;
    assign data_out                 = data_out_q;
    assign data_oe                  = data_oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Purpose : exercises interrupt_ack_sequencer (one normal instance, one AUTO_EOI instance) against a transaction-level model.
// Latency : inputs driven and outputs sampled 1 ns after each rising clock edge.
// Backpressure: n/a (bench).
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] interrupt;
    logic       inta_n;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;

    logic       int_out,   int_out_a;
    logic [7:0] isr,       isr_a;
    logic [7:0] hlis,      hlis_a;
    logic [7:0] clear_irr, clear_irr_a;
    logic [7:0] data_out,  data_out_a;
    logic       data_oe,   data_oe_a;

    int n_checks = 0;
    int n_fail   = 0;

    // Model ISR per instance: [0] normal, [1] AUTO_EOI.
    logic [7:0] m_isr [2];

    always #5 clk = ~clk;

    interrupt_ack_sequencer #(.AUTO_EOI(1'b0), .SPURIOUS_LEVEL(3'd7)) dut (
        .clk(clk), .rst_n(rst_n), .interrupt(interrupt), .inta_n(inta_n),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .vector_base(vector_base), .int_out(int_out), .in_service_register(isr),
        .highest_level_in_service(hlis), .clear_irr(clear_irr),
        .data_out(data_out), .data_oe(data_oe)
    );

    interrupt_ack_sequencer #(.AUTO_EOI(1'b1), .SPURIOUS_LEVEL(3'd7)) dut_ae (
        .clk(clk), .rst_n(rst_n), .interrupt(interrupt), .inta_n(inta_n),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .vector_base(vector_base), .int_out(int_out_a), .in_service_register(isr_a),
        .highest_level_in_service(hlis_a), .clear_irr(clear_irr_a),
        .data_out(data_out_a), .data_oe(data_oe_a)
    );

    // Index of the lowest set bit, as an integer.
    function automatic int first_set(input logic [7:0] x);
        for (int i = 0; i < 8; i++) begin
            if (x[i]) return i;
        end
        return -1;
    endfunction

    // One-hot mask of the lowest set bit, 0 if none.
    function automatic logic [7:0] lowest(input logic [7:0] x);
        int p;
        p = first_set(x);
        return (p < 0) ? 8'd0 : 8'(1 << p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; interrupt = 8'd0; inta_n = 1'b1; eoi_valid = 1'b0;
        eoi_specific = 1'b0; eoi_level = 3'd0; vector_base = 5'd0;
        tick(); tick();
        rst_n = 1'b1;
        m_isr[0] = 8'd0; m_isr[1] = 8'd0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if ({int_out, isr, clear_irr, data_out, data_oe, hlis} !== 34'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {int_out, isr, clear_irr, data_out, data_oe, hlis}); end
        n_checks++; if ({int_out_a, isr_a, clear_irr_a, data_out_a, data_oe_a, hlis_a} !== 34'd0) begin
            n_fail++; $display("FAIL reset_outputs_ae: got %h expected 0", {int_out_a, isr_a, clear_irr_a, data_out_a, data_oe_a, hlis_a}); end
    endtask

    // Full acknowledge transaction. EOI fields are applied on the INTA1 edge;
    // keep is the request presented while the second INTA pulse ends.
    task automatic do_ack(input logic [7:0] req, input bit drop, input logic [4:0] vb,
                          input bit ev, input bit es, input logic [2:0] el, input logic [7:0] keep);
        logic [7:0] set;
        logic [7:0] ecl;
        logic [2:0] lvl;
        logic [7:0] vec;
        interrupt = req; vector_base = vb;
        tick();
        n_checks++; if ({int_out, int_out_a} !== 2'b11) begin
            n_fail++; $display("FAIL int_raise: got %b expected 11", {int_out, int_out_a}); end
        if (drop) begin
            interrupt = 8'd0;
            tick();
            n_checks++; if (int_out !== 1'b1) begin
                n_fail++; $display("FAIL int_hold: got %b expected 1", int_out); end
        end
        set = drop ? 8'd0 : lowest(req);
        lvl = drop ? 3'd7 : 3'(first_set(req));
        vec = {vb, lvl};
        inta_n = 1'b0; eoi_valid = ev; eoi_specific = es; eoi_level = el;
        tick();
        eoi_valid = 1'b0; interrupt = 8'd0;
        for (int k = 0; k < 2; k++) begin
            ecl = !ev ? 8'd0 : (es ? 8'(1 << el) : lowest(m_isr[k]));
            m_isr[k] = (m_isr[k] & ~ecl) | set;
        end
        n_checks++; if ({int_out, int_out_a, data_oe} !== 3'b000) begin
            n_fail++; $display("FAIL inta1_int_drop: got %b expected 000", {int_out, int_out_a, data_oe}); end
        n_checks++; if ({clear_irr, clear_irr_a} !== {set, set}) begin
            n_fail++; $display("FAIL inta1_clear_irr: got %h expected %h", {clear_irr, clear_irr_a}, {set, set}); end
        n_checks++; if ({isr, isr_a} !== {m_isr[0], m_isr[1]}) begin
            n_fail++; $display("FAIL inta1_isr: got %h expected %h", {isr, isr_a}, {m_isr[0], m_isr[1]}); end
        tick();
        n_checks++; if (clear_irr !== 8'd0) begin
            n_fail++; $display("FAIL clear_irr_pulse: got %h expected 00", clear_irr); end
        inta_n = 1'b1;
        tick();
        n_checks++; if (data_oe !== 1'b0) begin
            n_fail++; $display("FAIL wait2_oe: got %b expected 0", data_oe); end
        inta_n = 1'b0;
        tick();
        n_checks++; if ({data_oe, data_out, data_oe_a, data_out_a} !== {1'b1, vec, 1'b1, vec}) begin
            n_fail++; $display("FAIL vector: got %h expected %h", {data_oe, data_out, data_oe_a, data_out_a}, {1'b1, vec, 1'b1, vec}); end
        tick();
        n_checks++; if ({data_oe, data_out} !== {1'b1, vec}) begin
            n_fail++; $display("FAIL vector_hold: got %h expected %h", {data_oe, data_out}, {1'b1, vec}); end
        interrupt = keep; inta_n = 1'b1;
        tick();
        if (!drop) m_isr[1] = m_isr[1] & ~set;
        n_checks++; if ({data_oe, data_out, data_oe_a, data_out_a, int_out} !== 19'd0) begin
            n_fail++; $display("FAIL ack_end_release: got %h expected 0", {data_oe, data_out, data_oe_a, data_out_a, int_out}); end
        n_checks++; if ({isr, isr_a} !== {m_isr[0], m_isr[1]}) begin
            n_fail++; $display("FAIL ack_end_isr: got %h expected %h", {isr, isr_a}, {m_isr[0], m_isr[1]}); end
        n_checks++; if ({hlis, hlis_a} !== {lowest(m_isr[0]), lowest(m_isr[1])}) begin
            n_fail++; $display("FAIL ack_end_hlis: got %h expected %h", {hlis, hlis_a}, {lowest(m_isr[0]), lowest(m_isr[1])}); end
    endtask

    task automatic do_eoi(input bit es, input logic [2:0] el);
        logic [7:0] ecl;
        eoi_valid = 1'b1; eoi_specific = es; eoi_level = el;
        tick();
        eoi_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ecl = es ? 8'(1 << el) : lowest(m_isr[k]);
            m_isr[k] = m_isr[k] & ~ecl;
        end
        n_checks++; if ({isr, isr_a, hlis, hlis_a} !== {m_isr[0], m_isr[1], lowest(m_isr[0]), lowest(m_isr[1])}) begin
            n_fail++; $display("FAIL eoi_isr: got %h expected %h", {isr, isr_a, hlis, hlis_a}, {m_isr[0], m_isr[1], lowest(m_isr[0]), lowest(m_isr[1])}); end
    endtask

    task automatic test_basic_ack();
        apply_reset();
        do_ack(8'b0000_0100, 1'b0, 5'b01000, 1'b0, 1'b0, 3'd0, 8'd0);
        n_checks++; if (isr !== 8'b0000_0100) begin
            n_fail++; $display("FAIL basic_isr: got %b expected 00000100", isr); end
    endtask

    task automatic test_back_to_back();
        do_ack(8'h20, 1'b0, 5'd3, 1'b0, 1'b0, 3'd0, 8'h40);
        tick();
        n_checks++; if (int_out !== 1'b1) begin
            n_fail++; $display("FAIL back_to_back_int: got %b expected 1", int_out); end
        do_ack(8'h40, 1'b0, 5'd3, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic test_spurious();
        apply_reset();
        do_ack(8'b1000_0000, 1'b1, 5'b10101, 1'b0, 1'b0, 3'd0, 8'd0);
        n_checks++; if ({isr, isr_a} !== 16'd0) begin
            n_fail++; $display("FAIL spurious_isr: got %h expected 0000", {isr, isr_a}); end
    endtask

    task automatic test_eoi();
        apply_reset();
        do_ack(8'h01, 1'b0, 5'd1, 1'b0, 1'b0, 3'd0, 8'd0);
        do_ack(8'h10, 1'b0, 5'd1, 1'b0, 1'b0, 3'd0, 8'd0);
        do_ack(8'h80, 1'b0, 5'd1, 1'b0, 1'b0, 3'd0, 8'd0);
        n_checks++; if (isr !== 8'b1001_0001) begin
            n_fail++; $display("FAIL eoi_setup_isr: got %b expected 10010001", isr); end
        do_eoi(1'b0, 3'd0);
        n_checks++; if ({isr, hlis} !== {8'b1001_0000, 8'b0001_0000}) begin
            n_fail++; $display("FAIL nonspecific_eoi: got %h expected 9010", {isr, hlis}); end
        do_eoi(1'b1, 3'd7);
        n_checks++; if (isr !== 8'b0001_0000) begin
            n_fail++; $display("FAIL specific_eoi: got %b expected 00010000", isr); end
        do_eoi(1'b0, 3'd0);
        do_eoi(1'b0, 3'd0);
        n_checks++; if ({isr, hlis} !== 16'd0) begin
            n_fail++; $display("FAIL eoi_empty_noop: got %h expected 0000", {isr, hlis}); end
    endtask

    task automatic test_auto_eoi();
        apply_reset();
        do_ack(8'b0000_0010, 1'b0, 5'd9, 1'b0, 1'b0, 3'd0, 8'd0);
        n_checks++; if ({isr_a, isr} !== {8'h00, 8'h02}) begin
            n_fail++; $display("FAIL auto_eoi_isr: got %h expected 0002", {isr_a, isr}); end
    endtask

    task automatic test_eoi_collision();
        apply_reset();
        do_ack(8'b0000_0100, 1'b0, 5'd2, 1'b1, 1'b1, 3'd2, 8'd0);
        n_checks++; if (isr[2] !== 1'b1) begin
            n_fail++; $display("FAIL eoi_set_collision: got %b expected 1", isr[2]); end
    endtask

    task automatic test_reset_in_ack2();
        apply_reset();
        interrupt = 8'h20; vector_base = 5'd17;
        tick();
        inta_n = 1'b0; tick(); interrupt = 8'd0;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        n_checks++; if ({data_oe, isr} !== {1'b1, 8'h20}) begin
            n_fail++; $display("FAIL pre_reset_ack2: got %h expected 120", {data_oe, isr}); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({data_oe, int_out, isr, data_out} !== 18'd0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0", {data_oe, int_out, isr, data_out}); end
        inta_n = 1'b1;
        tick();
        rst_n = 1'b1;
        m_isr[0] = 8'd0; m_isr[1] = 8'd0;
        tick();
        n_checks++; if ({int_out, data_oe} !== 2'b00) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected 00", {int_out, data_oe}); end
        do_ack(8'h08, 1'b0, 5'd4, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic test_idle_inta();
        interrupt = 8'd0;
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        n_checks++; if ({int_out, data_oe, clear_irr, isr} !== {2'b00, 8'd0, m_isr[0]}) begin
            n_fail++; $display("FAIL idle_inta_ignored: got %h expected %h", {int_out, data_oe, clear_irr, isr}, {2'b00, 8'd0, m_isr[0]}); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            do_ack(8'($urandom_range(1, 255)), ($urandom_range(0, 3) == 0), 5'($urandom),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 3'($urandom), 8'd0);
            if ($urandom_range(0, 1) == 1) do_eoi(bit'($urandom_range(0, 1)), 3'($urandom));
            if ($urandom_range(0, 4) == 0) test_idle_inta();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_ack();
        test_back_to_back();
        test_spurious();
        test_eoi();
        test_auto_eoi();
        test_eoi_collision();
        test_reset_in_ack2();
        test_idle_inta();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- CPU-facing end of the 8259A-style interrupt path.
- Consumes the one-hot winning request from the priority resolver and raises INT to the CPU.
- Runs the two-pulse INTA acknowledge sequence: sets the in-service bit on the first pulse and drives the vector byte on the second.
- Handles EOI commands and returns in_service_register and highest_level_in_service to the resolver, closing the loop.

Parameters:
AUTO_EOI, 0, 1 = clear the acknowledged ISR bit automatically at the end of the second INTA pulse.
SPURIOUS_LEVEL, 7, level whose vector is returned when the request vanishes before the first INTA.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
interrupt  in  8  one-hot winning request from priority resolver; 0 = none
inta_n  in  1  CPU acknowledge, active low, already synchronous to clk
eoi_valid  in  1  one-cycle EOI command strobe
eoi_specific  in  1  1 = specific EOI (use eoi_level), 0 = non-specific
eoi_level  in  3  level cleared by a specific EOI
vector_base  in  5  ICW2 T7..T3
int_out  out  1  interrupt request to CPU
in_service_register  out  8  ISR
highest_level_in_service  out  8  one-hot lowest-index set ISR bit; 0 when ISR empty
clear_irr  out  8  one-cycle one-hot pulse telling the IRR to drop the acknowledged bit
data_out  out  8  vector byte; 0 when data_oe = 0
data_oe  out  1  data bus drive enable

Behaviour:
- Reset (asynchronous, any state): state = IDLE; int_out, ISR, clear_irr, data_out and data_oe all 0; captured level = 0; inta_n history register = 1.
- Edge detect: fall = prev_inta_n & ~inta_n; rise = ~prev_inta_n & inta_n.
- IDLE:
  - interrupt != 0 -> int_out = 1 on the next edge; go REQ.
  - interrupt == 0 -> stay in IDLE.
- REQ:
  - int_out is held even if interrupt drops.
  - On fall with interrupt != 0: captured level = encode(interrupt); set that ISR bit; clear_irr = interrupt for exactly 1 cycle; int_out = 0; go ACK1.
  - On fall with interrupt == 0 (spurious): captured level = SPURIOUS_LEVEL; ISR unchanged; no clear_irr; int_out = 0; go ACK1.
- ACK1: on rise -> WAIT2.
- WAIT2: on fall -> data_out = {vector_base, level}; data_oe = 1; go ACK2. Latency is 1 clk after the falling edge is sampled.
- ACK2:
  - data_out is held stable while inta_n is low.
  - On rise: data_oe = 0; data_out = 0; go IDLE.
  - If AUTO_EOI = 1 and the acknowledge was not spurious, clear the captured ISR bit on that same edge.
- Back-to-back requests: IDLE with interrupt != 0 re-asserts int_out 1 cycle after returning, so the minimum INT gap is 1 cycle.
- Illegal extra INTA edges in IDLE are ignored.
- EOI (accepted in any state):
  - Non-specific: clear the lowest-index set ISR bit; no-op if ISR = 0.
  - Specific: clear bit eoi_level.
  - If an EOI clear and an INTA set hit the same bit on the same edge, the set wins; different bits both apply.
  - An AUTO_EOI clear and an explicit EOI on the same edge both apply.
- highest_level_in_service: combinational decode of the registered ISR; ISR = 0 -> 8'b0.
- interrupt with more than one bit set: lowest index taken.

Test Plan:
1. vector_base = 5'b01000, interrupt = 8'b00000100 -> int_out 1 next cycle. First INTA low -> ISR = 8'b00000100, clear_irr = 8'b00000100 for one cycle, int_out 0. Second INTA low -> data_out = 8'h42, data_oe 1; both return to 0 after inta_n rises.
2. interrupt = 8'b10000000, then drop interrupt to 0 before the first INTA -> int_out stays 1; vector = {vector_base, 3'd7}; ISR stays 0; no clear_irr pulse.
3. ISR = 8'b10010001; non-specific EOI -> ISR = 8'b10010000, highest_level_in_service = 8'b00010000. Then specific EOI level 7 -> ISR = 8'b00010000.
4. AUTO_EOI = 1, interrupt = 8'b00000010 through the full sequence -> ISR bit 1 sets on INTA1 and is cleared on the INTA2 rising edge; ISR ends at 0.
5. Assert rst_n = 0 while in ACK2 with data_oe = 1 -> data_oe, int_out and ISR are 0 immediately, without waiting for a clock edge; after release, state is IDLE.
6. Specific EOI for level 2 issued on the same edge as the INTA1 set of level 2 -> ISR bit 2 ends at 1.
